// File: rtl/ram_bist_pkg.sv
// Shared pattern codes, FSM encoding and per-bit pattern generator
// for the ram_bist self-test engine.
package ram_bist_pkg;

    localparam logic [1:0] PAT_ZERO  = 2'd0;
    localparam logic [1:0] PAT_ONES  = 2'd1;
    localparam logic [1:0] PAT_ADDR  = 2'd2;
    localparam logic [1:0] PAT_CHECK = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Bit bit_idx of exp(a); callers build a data_width word bit by bit,
    // passing abit = a[bit_idx] (0 beyond the address width) and a0 = a[0].
    function automatic logic exp_bit(
        input logic [1:0]  sel,
        input logic        abit,
        input logic        a0,
        input int unsigned bit_idx
    );
        logic r;
        r = 1'b0;
        unique case (sel)
            PAT_ZERO:  r = 1'b0;
            PAT_ONES:  r = 1'b1;
            PAT_ADDR:  r = abit;
            PAT_CHECK: r = ~bit_idx[0] ^ a0;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ram_bist_rdpipe.sv
// Address/valid tag shift register that tracks reads in flight
// so returning RAM data can be matched to its address.
module ram_bist_rdpipe
    import ram_bist_pkg::*;
#(
    parameter int addr_width   = 3,
    parameter int read_latency = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_valid,
    input  logic [addr_width-1:0] i_addr,
    output logic                  o_valid,
    output logic [addr_width-1:0] o_addr
);

    logic [read_latency-1:0] r_v;
    logic [addr_width-1:0]   r_a [read_latency];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_v <= '0;
            for (int i = 0; i < read_latency; i++) begin
                r_a[i] <= '0;
            end
        end else begin
            r_v[0] <= i_valid;
            r_a[0] <= i_addr;
            for (int i = 1; i < read_latency; i++) begin
                r_v[i] <= r_v[i-1];
                r_a[i] <= r_a[i-1];
            end
        end
    end

    assign o_valid = r_v[read_latency-1];
    assign o_addr  = r_a[read_latency-1];

endmodule

// File: rtl/ram_bist.sv
// Built-in self-test master for a single-port synchronous RAM:
// write a pattern everywhere, read it all back, flag the first mismatch.
module ram_bist
    import ram_bist_pkg::*;
#(
    parameter int data_width   = 8,
    parameter int addr_width   = 3,
    parameter int read_latency = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            pattern_sel,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [addr_width-1:0] fail_addr,
    output logic [data_width-1:0] fail_data,
    output logic                  ram_we,
    output logic                  ram_en,
    output logic [addr_width-1:0] ram_addr,
    output logic [data_width-1:0] ram_di,
    input  logic [data_width-1:0] ram_do
);

    localparam logic [addr_width-1:0] LAST_ADDR  = '1;
    localparam logic [1:0]            LAST_DRAIN = 2'(read_latency - 1);

    state_t                r_state;
    state_t                w_next;
    logic [addr_width-1:0] r_cnt;
    logic [1:0]            r_dcnt;
    logic [1:0]            r_pat;
    logic                  r_mis;
    logic                  r_pass;
    logic [addr_width-1:0] r_fail_addr;
    logic [data_width-1:0] r_fail_data;

    logic                  w_tag_valid;
    logic [addr_width-1:0] w_tag;
    logic [data_width-1:0] w_pat_cnt;
    logic [data_width-1:0] w_pat_tag;
    logic                  w_cmp_fail;
    logic                  w_mis_now;

    ram_bist_rdpipe #(
        .addr_width  (addr_width),
        .read_latency(read_latency)
    ) u_rdpipe (
        .clock  (clock),
        .reset  (reset),
        .i_valid(r_state == ST_READ),
        .i_addr (r_cnt),
        .o_valid(w_tag_valid),
        .o_addr (w_tag)
    );

    // Expected word for both the write address and the returning read tag
    for (genvar g = 0; g < data_width; g++) begin : g_pat
        logic w_abit_c;
        logic w_abit_t;
        if (g < addr_width) begin : g_a
            assign w_abit_c = r_cnt[g];
            assign w_abit_t = w_tag[g];
        end else begin : g_z
            assign w_abit_c = 1'b0;
            assign w_abit_t = 1'b0;
        end
        assign w_pat_cnt[g] = exp_bit(r_pat, w_abit_c, r_cnt[0], g);
        assign w_pat_tag[g] = exp_bit(r_pat, w_abit_t, w_tag[0], g);
    end

    assign w_cmp_fail = w_tag_valid && (ram_do != w_pat_tag);
    assign w_mis_now  = r_mis | w_cmp_fail;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        busy     = 1'b0;
        done     = 1'b0;
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_di   = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_WRITE;
            end
            ST_WRITE: begin
                busy     = 1'b1;
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = r_cnt;
                ram_di   = w_pat_cnt;
                if (r_cnt == LAST_ADDR) w_next = ST_READ;
            end
            ST_READ: begin
                busy     = 1'b1;
                ram_en   = 1'b1;
                ram_addr = r_cnt;
                if (r_cnt == LAST_ADDR) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (r_dcnt == LAST_DRAIN) w_next = ST_DONE;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_dcnt      <= '0;
            r_pat       <= PAT_ZERO;
            r_mis       <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_pat       <= pattern_sel;
                        r_cnt       <= '0;
                        r_mis       <= 1'b0;
                        r_pass      <= 1'b0;
                        r_fail_addr <= '0;
                        r_fail_data <= '0;
                    end
                end
                ST_WRITE, ST_READ: begin
                    r_cnt  <= r_cnt + 1'b1;
                    r_dcnt <= '0;
                end
                ST_DRAIN: begin
                    r_dcnt <= r_dcnt + 2'd1;
                    if (r_dcnt == LAST_DRAIN) r_pass <= ~w_mis_now;
                end
                default: ;
            endcase
            // Only the first mismatch is captured; later ones are ignored
            if (w_cmp_fail && !r_mis) begin
                r_mis       <= 1'b1;
                r_fail_addr <= w_tag;
                r_fail_data <= ram_do;
            end
        end
    end

    assign pass      = r_pass;
    assign fail_addr = r_fail_addr;
    assign fail_data = r_fail_data;

endmodule

// File: tb/tb_ram_bist.sv
// Directed bench for ram_bist: two instances (read latency 1 and 3)
// each with a behavioural RAM that can inject stuck-at faults.
module tb_ram_bist;

    logic       clk;
    logic       rst_n;
    logic       start1;
    logic       start3;
    logic [1:0] pat;

    logic       busy1, done1, pass1, we1, en1;
    logic [2:0] fa1, addr1;
    logic [7:0] fd1, di1, do1;
    logic       busy3, done3, pass3, we3, en3;
    logic [2:0] fa3, addr3;
    logic [7:0] fd3, di3, do3;

    logic [7:0] mem1 [8];
    logic [7:0] mem3 [8];
    logic [7:0] orm  [8];
    logic [7:0] andm [8];
    logic [7:0] p0, p1;

    int n_run;
    int n_fail;

    ram_bist #(.data_width(8), .addr_width(3), .read_latency(1)) u_dut1 (
        .clock(clk), .reset(rst_n), .start(start1), .pattern_sel(pat),
        .busy(busy1), .done(done1), .pass(pass1),
        .fail_addr(fa1), .fail_data(fd1),
        .ram_we(we1), .ram_en(en1), .ram_addr(addr1),
        .ram_di(di1), .ram_do(do1)
    );

    ram_bist #(.data_width(8), .addr_width(3), .read_latency(3)) u_dut3 (
        .clock(clk), .reset(rst_n), .start(start3), .pattern_sel(pat),
        .busy(busy3), .done(done3), .pass(pass3),
        .fail_addr(fa3), .fail_data(fd3),
        .ram_we(we3), .ram_en(en3), .ram_addr(addr3),
        .ram_di(di3), .ram_do(do3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] flt(input logic [7:0] m, input logic [2:0] a);
        return (m & andm[a]) | orm[a];
    endfunction

    always @(posedge clk) begin
        if (en1 && we1) mem1[addr1] <= di1;
        if (en1 && !we1) do1 <= flt(mem1[addr1], addr1);
        if (en3 && we3) mem3[addr3] <= di3;
        p0 <= (en3 && !we3) ? flt(mem3[addr3], addr3) : p0;
        p1  <= p0;
        do3 <= p1;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; k=0 is the first sample with busy expected high
    task automatic run(input int which, input logic [1:0] sel,
                       input int extra_at, output int bcnt,
                       output int didx, output int ndone,
                       output logic [63:0] wv);
        logic b, d, w;
        logic [2:0] a;
        logic [7:0] di;
        pat = sel;
        if (which == 1) start1 = 1'b1;
        else            start3 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
        bcnt = 0; didx = -1; ndone = 0; wv = '0;
        for (int k = 0; k < 40; k++) begin
            b  = (which == 1) ? busy1 : busy3;
            d  = (which == 1) ? done1 : done3;
            w  = (which == 1) ? we1   : we3;
            a  = (which == 1) ? addr1 : addr3;
            di = (which == 1) ? di1   : di3;
            if (b) bcnt++;
            if (d) begin
                ndone++;
                if (didx < 0) didx = k;
            end
            if (w) wv[8*int'(a) +: 8] = di;
            if (k == extra_at) begin
                if (which == 1) start1 = 1'b1;
                else            start3 = 1'b1;
            end
            @(negedge clk);
            start1 = 1'b0;
            start3 = 1'b0;
        end
    endtask

    int          bc, di_x, nd;
    logic [63:0] wv;

    initial begin
        n_run = 0; n_fail = 0;
        start1 = 1'b0; start3 = 1'b0; pat = 2'd0;
        do1 = '0; do3 = '0; p0 = '0; p1 = '0;
        for (int i = 0; i < 8; i++) begin
            orm[i] = 8'h00; andm[i] = 8'hFF;
            mem1[i] = 8'hC3; mem3[i] = 8'hC3;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_pass", pass1, 0);
        chk("rst_faddr", fa1, 0);
        chk("rst_fdata", fd1, 0);
        chk("rst_we", we1, 0);
        chk("rst_en", en1, 0);
        chk("rst_addr", addr1, 0);
        chk("rst_di", di1, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run(1, 2'd2, -1, bc, di_x, nd, wv);
        chk("addr_busy", bc, 17);
        chk("addr_done_at", di_x, 17);
        chk("addr_ndone", nd, 1);
        chk("addr_pass", pass1, 1);
        chk("addr_faddr", fa1, 0);
        chk("addr_wdata", wv, 64'h0706050403020100);

        run(1, 2'd3, -1, bc, di_x, nd, wv);
        chk("chk_wdata", wv, 64'hAA55AA55AA55AA55);
        chk("chk_pass", pass1, 1);
        chk("chk_done_at", di_x, 17);

        orm[4] = 8'h01;
        run(1, 2'd0, -1, bc, di_x, nd, wv);
        chk("stk_pass", pass1, 0);
        chk("stk_faddr", fa1, 4);
        chk("stk_fdata", fd1, 8'h01);
        chk("stk_done_at", di_x, 17);
        orm[4] = 8'h00;

        andm[2] = 8'hFE;
        andm[6] = 8'h7F;
        run(1, 2'd1, -1, bc, di_x, nd, wv);
        chk("two_pass", pass1, 0);
        chk("two_faddr", fa1, 2);
        chk("two_fdata", fd1, 8'hFE);
        chk("two_hold", fa1, 2);
        andm[2] = 8'hFF;
        andm[6] = 8'hFF;

        run(1, 2'd2, 5, bc, di_x, nd, wv);
        chk("ign_ndone", nd, 1);
        chk("ign_done_at", di_x, 17);
        chk("ign_pass", pass1, 1);
        chk("ign_fdata", fd1, 0);

        run(3, 2'd3, -1, bc, di_x, nd, wv);
        chk("lat3_busy", bc, 19);
        chk("lat3_done_at", di_x, 19);
        chk("lat3_pass", pass3, 1);
        chk("lat3_wdata", wv, 64'hAA55AA55AA55AA55);

        pat = 2'd2;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        bc = 0;
        while (!(we1 && addr1 == 3'd3) && bc < 20) begin
            @(negedge clk);
            bc++;
        end
        chk("mid_reach_a3", addr1, 3);
        rst_n = 1'b0;
        #1;
        chk("mid_en", en1, 0);
        chk("mid_we", we1, 0);
        chk("mid_busy", busy1, 0);
        nd = 0;
        repeat (3) begin
            @(negedge clk);
            if (done1) nd++;
        end
        chk("mid_nodone", nd, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run(1, 2'd2, -1, bc, di_x, nd, wv);
        chk("post_busy", bc, 17);
        chk("post_done_at", di_x, 17);
        chk("post_pass", pass1, 1);
        chk("post_wdata", wv, 64'h0706050403020100);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
